// File: rtl/bsg_tag_pkg.sv
// Shared types for the bsg_tag packet sender.
// Packet field bundle, start-bit value, sender state enum.
package bsg_tag_pkg;

  localparam int bsg_tag_max_lg_width_gp = 5;
  localparam int bsg_tag_max_lg_els_gp   = 8;
  localparam int bsg_tag_max_payload_gp  =
    (1 << bsg_tag_max_lg_width_gp) - 1;

  localparam logic bsg_tag_start_bit_gp = 1'b1;

  // Fields sized for the largest supported configuration.
  // Instances fill the low bits and leave the rest zero.
  typedef struct packed {
    logic [bsg_tag_max_lg_width_gp-1:0] len;
    logic                               data_not_reset;
    logic [bsg_tag_max_lg_els_gp-1:0]   nodeid;
    logic [bsg_tag_max_payload_gp-1:0]  payload;
  } bsg_tag_pkt_s;

  typedef enum logic [2:0] {
    e_idle,
    e_start,
    e_len,
    e_dnr,
    e_node,
    e_payload,
    e_mrst,
    e_gap
  } bsg_tag_send_state_e;

  function automatic int bsg_tag_max(int a, int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/bsg_counter_set_down.sv
// Loadable down-counter that saturates at zero.
// Ports: set_i/val_i load, down_i decrements, count_r_o current value.
module bsg_counter_set_down #(
  parameter int width_p = 8
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               set_i,
  input  logic [width_p-1:0] val_i,
  input  logic               down_i,
  output logic [width_p-1:0] count_r_o
);

  logic [width_p-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (set_i)
      count_d = val_i;
    else if (down_i && (count_q != '0))
      count_d = count_q - width_p'(1);
  end

  always_ff @(posedge clk_i or posedge reset_i)
    if (reset_i) count_q <= '0;
    else         count_q <= count_d;

  assign count_r_o = count_q;

endmodule

// File: rtl/bsg_tag_packet_sender.sv
// Serializes tag packets / master-reset runs onto tag_data_o, tag_en_o.
// Ports: v_i/ready_o command handshake, busy_o, registered serial outs.
module bsg_tag_packet_sender
  import bsg_tag_pkg::*;
#(
  parameter  int els_p        = 32,
  parameter  int lg_width_p   = 4,
  parameter  int gap_cycles_p = 4,
  parameter  int reset_len_p  = 64,
  localparam int lg_els_lp    = $clog2(els_p),
  localparam int pay_w_lp     = (1 << lg_width_p) - 1
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  v_i,
  output logic                  ready_o,
  input  logic                  master_reset_i,
  input  logic [lg_els_lp-1:0]  nodeid_i,
  input  logic                  data_not_reset_i,
  input  logic [lg_width_p-1:0] len_i,
  input  logic [pay_w_lp-1:0]   payload_i,
  output logic                  tag_data_o,
  output logic                  tag_en_o,
  output logic                  busy_o
);

  localparam int sh_w_lp  = bsg_tag_max_payload_gp;
  localparam int cnt_w_lp = $clog2(bsg_tag_max(
    bsg_tag_max(reset_len_p, gap_cycles_p),
    bsg_tag_max_payload_gp + 1));

  bsg_tag_send_state_e state_q, state_d;
  bsg_tag_pkt_s        cmd_q, cmd_d;
  logic [sh_w_lp-1:0]  shift_q, shift_d;
  logic                data_q, data_d;
  logic                en_q, en_d;
  logic [cnt_w_lp-1:0] cnt, cnt_ld;
  logic                field_entry;
  logic                accept;
  logic                last;
  logic                tx;

  assign ready_o = (state_q == e_idle);
  assign busy_o  = ~ready_o;
  assign accept  = v_i & ready_o;
  assign last    = (cnt == '0);

  bsg_counter_set_down #(
    .width_p(cnt_w_lp)
  ) field_cnt (
    .clk_i    (clk_i),
    .reset_i  (reset_i),
    .set_i    (field_entry),
    .val_i    (cnt_ld),
    .down_i   (1'b1),
    .count_r_o(cnt)
  );

  always_ff @(posedge clk_i or posedge reset_i)
    if (reset_i) state_q <= e_idle;
    else         state_q <= state_d;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      e_idle:    if (v_i)
                   state_d = master_reset_i ? e_mrst : e_start;
      e_start:   state_d = e_len;
      e_len:     if (last) state_d = e_dnr;
      e_dnr:     state_d = e_node;
      e_node:    if (last)
                   state_d = (cmd_q.len == '0) ? e_gap : e_payload;
      e_payload: if (last) state_d = e_gap;
      e_mrst:    if (last) state_d = e_gap;
      e_gap:     if (last) state_d = e_idle;
      default:   state_d = e_idle;
    endcase
  end

  // Outputs are computed from the state being entered so that the
  // registered tag pins line up with state_q.
  always_comb begin
    field_entry = (state_d != state_q);
    shift_d     = shift_q >> 1;
    cnt_ld      = '0;
    cmd_d       = cmd_q;
    if (accept) begin
      cmd_d = '0;
      cmd_d.len[lg_width_p-1:0]   = len_i;
      cmd_d.data_not_reset        = data_not_reset_i;
      cmd_d.nodeid[lg_els_lp-1:0] = nodeid_i;
      cmd_d.payload[pay_w_lp-1:0] = payload_i;
    end
    if (field_entry) begin
      unique case (state_d)
        e_start: begin
          shift_d = sh_w_lp'(bsg_tag_start_bit_gp);
        end
        e_len: begin
          shift_d = sh_w_lp'(cmd_q.len);
          cnt_ld  = cnt_w_lp'(lg_width_p - 1);
        end
        e_dnr: begin
          shift_d = sh_w_lp'(cmd_q.data_not_reset);
        end
        e_node: begin
          shift_d = sh_w_lp'(cmd_q.nodeid);
          cnt_ld  = cnt_w_lp'(lg_els_lp - 1);
        end
        e_payload: begin
          shift_d = cmd_q.payload;
          cnt_ld  = cnt_w_lp'(cmd_q.len) - cnt_w_lp'(1);
        end
        e_mrst: begin
          shift_d = '1;
          cnt_ld  = cnt_w_lp'(reset_len_p - 1);
        end
        e_gap: begin
          shift_d = '0;
          cnt_ld  = cnt_w_lp'(gap_cycles_p - 1);
        end
        default: begin
          shift_d = '0;
        end
      endcase
    end
    tx = (state_d != e_idle) && (state_d != e_gap);
    data_d = tx & ((state_d == e_mrst) | shift_d[0]);
    en_d   = tx;
  end

  always_ff @(posedge clk_i or posedge reset_i)
    if (reset_i) begin
      cmd_q   <= '0;
      shift_q <= '0;
      data_q  <= 1'b0;
      en_q    <= 1'b0;
    end else begin
      cmd_q   <= cmd_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      en_q    <= en_d;
    end

  assign tag_data_o = data_q;
  assign tag_en_o   = en_q;

endmodule

// File: tb/tb_bsg_tag_packet_sender.sv
// Bench for bsg_tag_packet_sender: vector table, scoreboard,
// exact-timing, back-to-back and mid-packet reset sequences.
module tb_bsg_tag_packet_sender;

  localparam int gap_lp  = 4;
  localparam int rlen_lp = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        v = 1'b0;
  logic        ready;
  logic        mr = 1'b0;
  logic [4:0]  node = '0;
  logic        dnr = 1'b0;
  logic [3:0]  len = '0;
  logic [14:0] pay = '0;
  logic        tdata, ten, busy;

  always #5 clk = ~clk;

  bsg_tag_packet_sender #(
    .els_p(32), .lg_width_p(4),
    .gap_cycles_p(gap_lp), .reset_len_p(rlen_lp)
  ) dut (
    .clk_i(clk), .reset_i(rst), .v_i(v), .ready_o(ready),
    .master_reset_i(mr), .nodeid_i(node),
    .data_not_reset_i(dnr), .len_i(len), .payload_i(pay),
    .tag_data_o(tdata), .tag_en_o(ten), .busy_o(busy)
  );

  int n_vec = 0;
  int n_err = 0;
  bit mon_en = 1'b0;
  bit sb[$];

  typedef struct {
    bit          m;
    logic [4:0]  nd;
    bit          d;
    logic [3:0]  ln;
    logic [14:0] p;
    int          cyc;
  } vec_t;

  vec_t tbl[6];

  task automatic check(string nm, logic [31:0] got,
                       logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h at %0t",
               nm, got, want, $time);
    end
  endtask

  function automatic void push_pkt(bit m, logic [4:0] nd, bit d,
                                   logic [3:0] ln, logic [14:0] p);
    if (m) begin
      for (int i = 0; i < rlen_lp; i++) sb.push_back(1'b1);
    end else begin
      sb.push_back(1'b1);
      for (int i = 0; i < 4; i++) sb.push_back(ln[i]);
      sb.push_back(d);
      for (int i = 0; i < 5; i++) sb.push_back(nd[i]);
      for (int i = 0; i < int'(ln); i++) sb.push_back(p[i]);
    end
  endfunction

  always @(negedge clk) begin
    if (mon_en && !rst) begin
      if (ten) begin
        if (sb.size() == 0) begin
          check("sb_extra_bit", 32'(tdata), 32'hdead);
        end else begin
          bit e;
          e = sb.pop_front();
          check("sb_bit", 32'(tdata), 32'(e));
        end
      end else begin
        check("idle_data", 32'(tdata), 0);
      end
    end
  end

  task automatic send(bit m, logic [4:0] nd, bit d,
                      logic [3:0] ln, logic [14:0] p, bit track);
    int n;
    n = 0;
    while (!ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check("send_ready_timeout", 0, 1);
    v = 1'b1; mr = m; node = nd; dnr = d; len = ln; pay = p;
    if (track) push_pkt(m, nd, d, ln, p);
    @(posedge clk);
    #1;
    v = 1'b0;
    mr = 1'($urandom);
    node = 5'($urandom);
    dnr = 1'($urandom);
    len = 4'($urandom);
    pay = 15'($urandom);
  endtask

  task automatic measure(int exp_cyc);
    int n;
    int g;
    n = 0;
    @(negedge clk);
    while (ten && n < 300) begin
      n++;
      @(negedge clk);
    end
    check("en_cycles", 32'(n), 32'(exp_cyc));
    g = 0;
    while (!ready && g < 50) begin
      g++;
      @(negedge clk);
    end
    check("gap_cycles", 32'(g), 32'(gap_lp));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: no finish by %0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    logic [0:13] exp1;
    int n;
    int g;

    tbl[0] = '{1'b0, 5'd31, 1'b0, 4'd0,  15'h7fff, 11};
    tbl[1] = '{1'b1, 5'd7,  1'b1, 4'd9,  15'h1234, 64};
    tbl[2] = '{1'b0, 5'd0,  1'b1, 4'd15, 15'h7fff, 26};
    tbl[3] = '{1'b0, 5'd17, 1'b1, 4'd1,  15'h7ff1, 12};
    tbl[4] = '{1'b0, 5'd5,  1'b0, 4'd8,  15'h40a5, 19};
    tbl[5] = '{1'b0, 5'd31, 1'b1, 4'd7,  15'h005a, 18};

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_data", 32'(tdata), 0);
    check("rst_en", 32'(ten), 0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_ready", 32'(ready), 1);
    check("rst_busy", 32'(busy), 0);
    check("rst_en_after", 32'(ten), 0);

    // Exact timing of a short data packet
    exp1 = 14'b1_1100_1_11000_101;
    send(1'b0, 5'd3, 1'b1, 4'd3, 15'h7ffd, 1'b0);
    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      check("p1_en", 32'(ten), 1);
      check("p1_bit", 32'(tdata), 32'(exp1[k]));
    end
    for (int k = 0; k < gap_lp; k++) begin
      @(negedge clk);
      check("p1_gap_en", 32'(ten), 0);
      check("p1_gap_data", 32'(tdata), 0);
      check("p1_gap_ready", 32'(ready), 0);
    end
    @(negedge clk);
    check("p1_ready", 32'(ready), 1);

    // Vector table through the scoreboard
    mon_en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      send(tbl[i].m, tbl[i].nd, tbl[i].d, tbl[i].ln, tbl[i].p, 1'b1);
      measure(tbl[i].cyc);
    end

    // Random packets
    for (int i = 0; i < 6; i++) begin
      logic [3:0] rl;
      rl = 4'($urandom_range(0, 15));
      send(1'b0, 5'($urandom), 1'($urandom), rl,
           15'($urandom), 1'b1);
      measure(11 + int'(rl));
    end

    // Back-to-back with v_i held high
    n = 0;
    while (!ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    v = 1'b1; mr = 1'b0; node = 5'd9; dnr = 1'b1;
    len = 4'd2; pay = 15'h0003;
    push_pkt(1'b0, 5'd9, 1'b1, 4'd2, 15'h0003);
    @(posedge clk);
    #1;
    node = 5'd20; dnr = 1'b0; len = 4'd5; pay = 15'h0015;
    push_pkt(1'b0, 5'd20, 1'b0, 4'd5, 15'h0015);
    n = 0;
    @(negedge clk);
    while (ten && n < 300) begin
      check("b2b_no_accept", 32'(ready), 0);
      n++;
      @(negedge clk);
    end
    check("b2b_a_cycles", 32'(n), 13);
    g = 0;
    while (!ten && g < 50) begin
      if (busy) check("b2b_no_accept", 32'(ready), 0);
      g++;
      @(negedge clk);
    end
    check("b2b_spacing", 32'(g), 32'(gap_lp + 1));
    v = 1'b0;
    n = 0;
    while (ten && n < 300) begin
      n++;
      @(negedge clk);
    end
    check("b2b_b_cycles", 32'(n), 16);
    g = 0;
    while (!ready && g < 50) begin
      g++;
      @(negedge clk);
    end
    check("b2b_b_gap", 32'(g), 32'(gap_lp));
    check("sb_empty_b2b", 32'(sb.size()), 0);

    // Reset during the 6th bit (dnr=1 makes that bit a 1)
    mon_en = 1'b0;
    send(1'b0, 5'd6, 1'b1, 4'd4, 15'h000f, 1'b0);
    repeat (6) @(negedge clk);
    check("mid_pre_bit", 32'(tdata), 1);
    rst = 1'b1;
    #1;
    check("mid_rst_data", 32'(tdata), 0);
    check("mid_rst_en", 32'(ten), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("mid_ready", 32'(ready), 1);
    check("mid_busy", 32'(busy), 0);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      check("mid_resid_en", 32'(ten), 0);
      check("mid_resid_data", 32'(tdata), 0);
    end

    // Sender still works after the abandoned packet
    mon_en = 1'b1;
    send(1'b0, 5'd12, 1'b1, 4'd6, 15'h0029, 1'b1);
    measure(17);
    check("sb_empty_end", 32'(sb.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
